// File: rtl/csa_array_mult_if.sv
// Operand/product bundle for the carry-save array multiplier.
// The master drives both operands and reads the product. The slave (the multiplier) does the reverse.
interface csa_array_mult_if;
  logic [15:0] a;
  logic [15:0] b;
  logic [31:0] out;

  modport master (output a, output b, input out);
  modport slave  (input a, input b, output out);
endinterface

// File: rtl/csa_array_mult.sv
// Unsigned 16x16 carry-save array multiplier with a registered 32-bit product.
// The first partial-product row seeds the array. Fifteen full-adder rows then add one
// partial-product row each, and sum and carry vectors pass between rows without rippling.
// The low product bits come out of each row's LSB. A 16-bit ripple adder merges the last
// sum and carry rows into the high half of the product.
module csa_array_mult (
  input  logic             clk,
  input  logic             reset,
  csa_array_mult_if.slave  bus
);

  logic [31:0] product;

  // Carry-save array plus final carry-propagate adder, purely combinational.
  always_comb begin : array_blk
    // Row i, bit j: s_row has weight i+j. c_row has weight i+j+1.
    logic [15:0] pp    [16];
    logic [15:0] s_row [16];
    logic [15:0] c_row [16];
    logic [15:0] s_shift;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        rc;

    // NOTE: blocking assignments here, because each row reads values written earlier in
    // this same pass. Every variable gets a default first, so no path can infer a latch.
    pp      = '{default: '0};
    s_row   = '{default: '0};
    c_row   = '{default: '0};
    s_shift = '0;
    lo      = '0;
    hi      = '0;
    rc      = 1'b0;

    for (int i = 0; i < 16; i++) begin
      pp[i] = bus.a & {16{bus.b[i]}};
    end

    // Row 0 has no adders. Its sums are the first partial products, and it has no carries.
    s_row[0] = pp[0];
    c_row[0] = '0;
    lo[0]    = s_row[0][0];

    // Fifteen full-adder rows. A previous-row sum at bit j+1 and a previous-row carry at bit j
    // both have weight i+j, so they line up with pp[i][j]. Carries move diagonally into the next row.
    for (int i = 1; i < 16; i++) begin
      s_shift = {1'b0, s_row[i-1][15:1]};
      for (int j = 0; j < 16; j++) begin
        s_row[i][j] = pp[i][j] ^ s_shift[j] ^ c_row[i-1][j];
        c_row[i][j] = (pp[i][j] & s_shift[j]) | (pp[i][j] & c_row[i-1][j]) |
                      (s_shift[j] & c_row[i-1][j]);
      end
      lo[i] = s_row[i][0];
    end

    // A ripple adder merges the last row into product bits 31..16. The exact product fits in
    // 32 bits, so the final carry out is always zero.
    s_shift = {1'b0, s_row[15][15:1]};
    for (int j = 0; j < 16; j++) begin
      hi[j] = s_shift[j] ^ c_row[15][j] ^ rc;
      rc    = (s_shift[j] & c_row[15][j]) | (s_shift[j] & rc) | (c_row[15][j] & rc);
    end

    product = {hi, lo};
  end

  // Output register. Reset takes priority and discards the product in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking for state, so every register samples values from before the edge.
    // The reset is synchronous, so it acts only at a clock edge.
    if (reset) begin
      bus.out <= '0;
    end else begin
      bus.out <= product;
    end
  end

endmodule

// File: tb/tb_csa_array_mult.sv
// Self-checking bench for csa_array_mult. Each edge is compared with plain a*b arithmetic,
// or with zero when reset is high.
module tb_csa_array_mult;

  logic clk;
  logic reset;
  csa_array_mult_if bus ();

  csa_array_mult dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference model: reset clears the output, otherwise out is the exact product.
  function automatic logic [31:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic rv);
    longint unsigned p;
    p = longint'(av) * longint'(bv);
    return rv ? 32'd0 : p[31:0];
  endfunction

  // Drive one set of inputs, clock one edge, and check out shortly after the edge.
  task automatic apply(input logic [15:0] av, input logic [15:0] bv, input logic rv,
                       input string tag);
    bus.a = av;
    bus.b = bv;
    reset = rv;
    @(posedge clk);
    #1;
    check(tag, bus.out, model(av, bv, rv));
  endtask

  logic [31:0] held;
  logic [15:0] ra;
  logic [15:0] rb;
  logic        rr;

  initial begin
    bus.a = '0;
    bus.b = '0;
    reset = 1'b1;
    @(negedge clk);

    // Reset clears the output, then the first edge after reset loads a*b.
    apply(16'h0809, 16'h0091, 1'b1, "reset_clear");
    apply(16'h0809, 16'h0091, 1'b0, "post_reset");
    check("post_reset_value", bus.out, 32'd298265);

    apply(16'h081D, 16'h0019, 1'b0, "basic");
    check("basic_value", bus.out, 32'd51925);

    // Boundary values.
    apply(16'hFFFF, 16'hFFFF, 1'b0, "max_max");
    check("max_max_value", bus.out, 32'hFFFE0001);
    apply(16'hFFFF, 16'h0001, 1'b0, "max_one");
    apply(16'h0000, 16'h1234, 1'b0, "zero_a");
    apply(16'h8000, 16'h0002, 1'b0, "carry_across");
    check("carry_across_value", bus.out, 32'h00010000);
    apply(16'h1234, 16'h0000, 1'b0, "zero_b");
    apply(16'h8000, 16'h8000, 1'b0, "msb_msb");

    // Operands changed between edges must not reach the output before the next edge.
    held  = bus.out;
    bus.a = 16'hABCD;
    bus.b = 16'h4321;
    #3;
    check("hold_between_edges", bus.out, held);
    @(posedge clk);
    #1;
    check("hold_then_load", bus.out, model(16'hABCD, 16'h4321, 1'b0));

    // Back-to-back streaming with a one-cycle lag.
    apply(16'd3,   16'd5,   1'b0, "stream0");
    check("stream0_value", bus.out, 32'd15);
    apply(16'd7,   16'd9,   1'b0, "stream1");
    check("stream1_value", bus.out, 32'd63);
    apply(16'd100, 16'd200, 1'b0, "stream2");
    check("stream2_value", bus.out, 32'd20000);

    // Reset mid-stream while the operands keep changing.
    apply(16'h1111, 16'h2222, 1'b0, "mid_pre");
    apply(16'h3333, 16'h4444, 1'b1, "mid_rst0");
    apply(16'h5555, 16'h6666, 1'b1, "mid_rst1");
    apply(16'h7777, 16'h8888, 1'b0, "mid_release");
    apply(16'h9999, 16'hAAAA, 1'b0, "mid_after");

    // Walking-one operands exercise every row and every column of the array.
    for (int i = 0; i < 16; i++) begin
      apply(16'h0001 << i, 16'hFFFF, 1'b0, "walk_a");
      apply(16'hFFFF, 16'h0001 << i, 1'b0, "walk_b");
    end

    // Random sweep with occasional resets.
    for (int n = 0; n < 10000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rr = ($urandom_range(0, 31) == 0);
      apply(ra, rb, rr, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
